// File: rtl/coord_pkg.sv
// ----------------------------------------------------------------------------
// coord_pkg
// Shared definitions for the coordinate stream reader.
//   - rd_state_e  : reader state machine encoding
//   - COORD_W_DEF : default coordinate width
//   - ADDR_W_DEF  : default coordinate memory address width
//   - coord_t     : one (x, y) pair at the default coordinate width
// ----------------------------------------------------------------------------
package coord_pkg;

    localparam int COORD_W_DEF = 8;
    localparam int ADDR_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } rd_state_e;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
    } coord_t;

endpackage

// File: rtl/coord_stream_reader.sv
// ----------------------------------------------------------------------------
// coord_stream_reader
// Walks the coordinate memory from address 0 to coord_count-1 after entry has
// finished. Each pair is fetched with a synchronous read of the X and Y RAMs
// and then offered to the pathfinding engine on a valid/ready stream. One
// pair is outstanding at a time: ISSUE -> WAIT -> PRESENT, repeated until the
// final pair is accepted, after which the reader sits in DONE until re-armed.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             begin a pass (honoured only in IDLE or DONE)
//   coord_count       number of stored pairs, 0..2^ADDR_W, sampled at start
//   rd_en, rd_addr    memory read strobe and address (address holds when idle)
//   x_rdata, y_rdata  RAM read data, valid one cycle after rd_en
//   coord_valid/ready stream handshake
//   x_out, y_out      current pair, stable while coord_valid is high
//   coord_last        marks the final pair of the pass
//   busy, done        pass in progress / pass complete (level)
//
// Optional build macro COORD_HEX_DISP_EN adds hex0..hex5 nibble outputs for a
// seven-segment display: hex3..hex0 = {y_out[7:4], y_out[3:0], x_out[7:4],
// x_out[3:0]}, hex5/hex4 = idx[3:0]/idx[7:4]. The nibble split is fixed, so
// that build needs COORD_W = 8 and ADDR_W = 8.
// ----------------------------------------------------------------------------
module coord_stream_reader
    import coord_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W:0]    coord_count,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COORD_W-1:0] x_rdata,
    input  logic [COORD_W-1:0] y_rdata,
    output logic               coord_valid,
    input  logic               coord_ready,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               coord_last,
    output logic               busy,
`ifdef COORD_HEX_DISP_EN
    output logic [3:0]         hex0,
    output logic [3:0]         hex1,
    output logic [3:0]         hex2,
    output logic [3:0]         hex3,
    output logic [3:0]         hex4,
    output logic [3:0]         hex5,
`endif
    output logic               done
);

    rd_state_e          r_state;
    logic [ADDR_W:0]    r_idx;
    logic [ADDR_W:0]    r_total;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_last;
    logic               r_busy;
    logic               r_done;

`ifdef COORD_HEX_DISP_EN
    logic [3:0]         r_hex0;
    logic [3:0]         r_hex1;
    logic [3:0]         r_hex2;
    logic [3:0]         r_hex3;
    logic [3:0]         r_hex4;
    logic [3:0]         r_hex5;
`endif

    // idx and total are ADDR_W+1 bits so a full memory (2^ADDR_W pairs) is
    // representable and the last-pair test never wraps.
    logic [ADDR_W:0]    w_idx_next;
    logic               w_is_last;

    assign w_idx_next = r_idx + (ADDR_W+1)'(1);
    assign w_is_last  = (r_idx == (r_total - (ADDR_W+1)'(1)));

    // Reader state machine; every output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_total   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef COORD_HEX_DISP_EN
            r_hex0    <= 4'd0;
            r_hex1    <= 4'd0;
            r_hex2    <= 4'd0;
            r_hex3    <= 4'd0;
            r_hex4    <= 4'd0;
            r_hex5    <= 4'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_total <= coord_count;
                        r_idx   <= '0;
                        if (coord_count == '0) begin
                            // Empty pass: straight to DONE without a read.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data from the ISSUE cycle is on the bus now.
                    r_x     <= x_rdata;
                    r_y     <= y_rdata;
                    r_last  <= w_is_last;
                    r_valid <= 1'b1;
                    r_state <= ST_PRESENT;
`ifdef COORD_HEX_DISP_EN
                    r_hex0  <= x_rdata[3:0];
                    r_hex1  <= x_rdata[7:4];
                    r_hex2  <= y_rdata[3:0];
                    r_hex3  <= y_rdata[7:4];
                    r_hex4  <= r_idx[7:4];
                    r_hex5  <= r_idx[3:0];
`endif
                end
                ST_PRESENT: begin
                    if (coord_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_rd_addr <= w_idx_next[ADDR_W-1:0];
                            r_rd_en   <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign coord_valid = r_valid;
    assign x_out       = r_x;
    assign y_out       = r_y;
    assign coord_last  = r_last;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef COORD_HEX_DISP_EN
    assign hex0 = r_hex0;
    assign hex1 = r_hex1;
    assign hex2 = r_hex2;
    assign hex3 = r_hex3;
    assign hex4 = r_hex4;
    assign hex5 = r_hex5;
`endif

endmodule
